// File: rtl/savestate_reg_sequencer.sv
// savestate_reg_sequencer: walks every savestate register index and
// streams each value between the register bus and the memory port.
module savestate_reg_sequencer #(
  parameter int                NUM_REGS  = 64,
  parameter int                BUS_LAT   = 2,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ss_save,
  input  logic              ss_load,
  input  logic              ss_defaults,
  output logic              busy,
  output logic              done,
  output logic [9:0]        SaveStateBus_Adr,
  output logic [63:0]       SaveStateBus_Din,
  output logic              SaveStateBus_wren,
  output logic              SaveStateBus_rst,
  input  logic [63:0]       SaveStateBus_Dout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [3:0] {
    IDLE,
    DEF,
    SV_ADR,
    SV_WR,
    NEXT_S,
    LD_REQ,
    LD_WR,
    NEXT_L,
    FIN
  } state_t;

  localparam logic [9:0] LAST_IDX = 10'(NUM_REGS - 1);
  localparam logic [2:0] LAT_END  = 3'(BUS_LAT - 1);

  state_t      state, state_nx;
  logic [9:0]  idx, idx_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [63:0] wdata_q, wdata_nx;
  logic [63:0] din_q, din_nx;
  logic [ADDR_W-1:0] addr_cur;
  logic        last;

  assign last      = (idx == LAST_IDX);
  assign addr_cur  = BASE_ADDR + ADDR_W'(idx);
  assign mem_wdata = wdata_q;
  assign SaveStateBus_Din = din_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      wdata_q <= '0;
      din_q   <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      wdata_q <= wdata_nx;
      din_q   <= din_nx;
    end
  end

  always_comb begin
    state_nx          = state;
    idx_nx            = idx;
    cnt_nx            = cnt;
    wdata_nx          = wdata_q;
    din_nx            = din_q;
    busy              = 1'b1;
    done              = 1'b0;
    SaveStateBus_Adr  = idx;
    SaveStateBus_wren = 1'b0;
    SaveStateBus_rst  = 1'b0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    unique case (state)
      IDLE: begin
        busy             = 1'b0;
        SaveStateBus_Adr = '0;
        idx_nx           = '0;
        cnt_nx           = '0;
        if (ss_defaults)  state_nx = DEF;
        else if (ss_save) state_nx = SV_ADR;
        else if (ss_load) state_nx = LD_REQ;
      end
      DEF: begin
        SaveStateBus_rst = 1'b1;
        state_nx         = FIN;
      end
      SV_ADR: begin
        cnt_nx = cnt + 3'd1;
        // read data is valid on the last latency cycle
        if (cnt == LAT_END) begin
          cnt_nx   = '0;
          wdata_nx = SaveStateBus_Dout;
          state_nx = SV_WR;
        end
      end
      SV_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_cur;
        if (mem_ack) state_nx = NEXT_S;
      end
      NEXT_S: begin
        if (last) begin
          state_nx = FIN;
        end else begin
          idx_nx   = idx + 10'd1;
          state_nx = SV_ADR;
        end
      end
      LD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = addr_cur;
        if (mem_ack) begin
          din_nx   = mem_rdata;
          state_nx = LD_WR;
        end
      end
      LD_WR: begin
        SaveStateBus_wren = 1'b1;
        state_nx          = NEXT_L;
      end
      NEXT_L: begin
        if (last) begin
          state_nx = FIN;
        end else begin
          idx_nx   = idx + 10'd1;
          state_nx = LD_REQ;
        end
      end
      FIN: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_savestate_reg_sequencer.sv
// Bench for savestate_reg_sequencer: bus/memory models, transaction
// monitors and per-feature scenario tasks.
module tb_savestate_reg_sequencer;

  localparam int N    = 64;
  localparam int LAT  = 2;
  localparam int N2   = 20;
  localparam logic [15:0] BASE2 = 16'hFFF0;

  typedef struct packed {
    logic [15:0] a;
    logic [63:0] d;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ss_save = 1'b0;
  logic        ss_load = 1'b0;
  logic        ss_defaults = 1'b0;
  logic        busy, done;
  logic [9:0]  bus_adr;
  logic [63:0] bus_din;
  logic        bus_wren, bus_rst;
  logic [63:0] bus_dout = '0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  logic        s2_save = 1'b0;
  logic        s2_zero = 1'b0;
  logic        busy2, done2;
  logic [9:0]  b2_adr;
  logic [63:0] b2_din, b2_dout;
  logic        b2_wren, b2_rst;
  logic        m2_req, m2_we, m2_ack;
  logic [15:0] m2_addr;
  logic [63:0] m2_wdata;
  logic [63:0] m2_rdata = '0;

  int checks = 0;
  int errors = 0;
  int stall = 0;
  bit spur_en = 1'b0;
  bit spur = 1'b0;
  int age = 0;
  logic [63:0] ld_seed = '0;

  always #5 clk = ~clk;

  savestate_reg_sequencer #(
    .NUM_REGS(N), .BUS_LAT(LAT), .ADDR_W(16), .BASE_ADDR(16'h0000)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .ss_save(ss_save), .ss_load(ss_load), .ss_defaults(ss_defaults),
    .busy(busy), .done(done),
    .SaveStateBus_Adr(bus_adr), .SaveStateBus_Din(bus_din),
    .SaveStateBus_wren(bus_wren), .SaveStateBus_rst(bus_rst),
    .SaveStateBus_Dout(bus_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  savestate_reg_sequencer #(
    .NUM_REGS(N2), .BUS_LAT(1), .ADDR_W(16), .BASE_ADDR(BASE2)
  ) u_wrap (
    .clk(clk), .reset_n(reset_n),
    .ss_save(s2_save), .ss_load(s2_zero), .ss_defaults(s2_zero),
    .busy(busy2), .done(done2),
    .SaveStateBus_Adr(b2_adr), .SaveStateBus_Din(b2_din),
    .SaveStateBus_wren(b2_wren), .SaveStateBus_rst(b2_rst),
    .SaveStateBus_Dout(b2_dout),
    .mem_req(m2_req), .mem_we(m2_we), .mem_addr(m2_addr),
    .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .mem_ack(m2_ack)
  );

  function automatic logic [63:0] sv_word(input logic [9:0] i);
    return 64'hA5A5_0000_0000_0000 | {54'd0, i};
  endfunction

  function automatic logic [63:0] wrap_word(input logic [9:0] i);
    return 64'hC0DE_0000_0000_0000 | {54'd0, i};
  endfunction

  function automatic logic [63:0] ld_word(input logic [15:0] a);
    if (a == 16'd0)  return 64'hE064_0000_0000_0000;
    if (a == 16'd19) return 64'h0000_0000_0000_7FFF;
    return {ld_seed[31:0] ^ {16'd0, a}, ld_seed[63:32] + {16'd0, a}};
  endfunction

  // register bus: one pipeline stage of read latency
  always @(posedge clk) bus_dout <= sv_word(bus_adr);
  assign b2_dout = wrap_word(b2_adr);

  // memory: ack after 'stall' cycles of held request, spurious acks when idle
  assign mem_ack   = (mem_req && age == stall) || (!mem_req && spur);
  assign mem_rdata = ld_word(mem_addr);
  assign m2_ack    = m2_req;

  always @(posedge clk) begin
    age  <= (mem_req && !mem_ack) ? age + 1 : 0;
    spur <= spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  xfer_t wr_q[$];
  xfer_t wren_q[$];
  xfer_t wr2_q[$];
  int busy_cyc = 0, done_cnt = 0, rst_cnt = 0, rd_cnt = 0;
  int wide_cnt = 0, viol_cnt = 0;
  logic p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_wren = 1'b0;
  logic [15:0] p_addr = '0;

  always @(negedge clk) begin
    if (busy)    busy_cyc <= busy_cyc + 1;
    if (done)    done_cnt <= done_cnt + 1;
    if (bus_rst) rst_cnt  <= rst_cnt + 1;
    if (mem_req && mem_ack) begin
      if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
      else        rd_cnt <= rd_cnt + 1;
    end
    if (bus_wren) begin
      wren_q.push_back({6'd0, bus_adr, bus_din});
      if (p_wren) wide_cnt <= wide_cnt + 1;
    end
    if (p_req && !p_ack &&
        (!mem_req || mem_addr != p_addr || mem_we != p_we))
      viol_cnt <= viol_cnt + 1;
    if (m2_req && m2_ack && m2_we) wr2_q.push_back({m2_addr, m2_wdata});
    p_req  <= mem_req;
    p_ack  <= mem_ack;
    p_we   <= mem_we;
    p_addr <= mem_addr;
    p_wren <= bus_wren;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input bit s, input bit l, input bit d);
    ss_save = s; ss_load = l; ss_defaults = d;
    tick();
    ss_save = 1'b0; ss_load = 1'b0; ss_defaults = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit ok);
    int cyc;
    cyc = 0;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
    end
    ok = done;
  endtask

  task automatic check_save_data(input string tag);
    checks++;
    if (wr_q.size() != N) begin
      errors++;
      $display("FAIL %s_count: got %0d writes, want %0d", tag, wr_q.size(), N);
    end
    for (int i = 0; i < wr_q.size() && i < N; i++) begin
      checks++;
      if (wr_q[i].a !== 16'(i) || wr_q[i].d !== sv_word(10'(i))) begin
        errors++;
        $display("FAIL %s_wr%0d: got %h/%h, want %h/%h", tag, i,
                 wr_q[i].a, wr_q[i].d, 16'(i), sv_word(10'(i)));
      end
    end
  endtask

  task automatic test_reset();
    logic [217:0] outs;
    reset_n = 1'b0;
    tick(); tick();
    outs = {busy, done, mem_req, mem_we, bus_wren, bus_rst, bus_adr,
            mem_addr, mem_wdata, bus_din};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    checks++;
    if ({busy2, done2, m2_req, b2_adr, m2_addr} !== '0) begin
      errors++;
      $display("FAIL reset_wrap: got %b/%h/%h, want 0", busy2, b2_adr, m2_addr);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_save();
    int b0, d0, r0;
    bit ok;
    stall = 0; spur_en = 1'b0;
    wr_q.delete();
    b0 = busy_cyc; d0 = done_cnt; r0 = rd_cnt;
    pulse(1'b1, 1'b0, 1'b0);
    run_until_done(5000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL save_timeout: done=%b, want 1", done); end
    tick(); tick();
    check_save_data("save");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL save_done: got %0d pulses, want 1", done_cnt - d0);
    end
    checks++;
    if (busy_cyc - b0 != N * (LAT + 2)) begin
      errors++;
      $display("FAIL save_busy: got %0d, want %0d", busy_cyc - b0, N * (LAT + 2));
    end
    checks++;
    if (rd_cnt != r0) begin errors++; $display("FAIL save_reads: got %0d, want 0", rd_cnt - r0); end
  endtask

  task automatic test_reset_mid_save();
    int d0, cyc;
    bit ok;
    stall = 0;
    pulse(1'b1, 1'b0, 1'b0);
    cyc = 0;
    while (bus_adr != 10'd5 && cyc < 500) begin tick(); cyc++; end
    checks++;
    if (bus_adr != 10'd5) begin errors++; $display("FAIL midrst_reach: adr=%0d, want 5", bus_adr); end
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_req, mem_we, bus_wren, bus_rst, bus_adr, mem_addr} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b req=%b adr=%0d, want all 0", busy, mem_req, bus_adr);
    end
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL midrst_done: got %0d pulses, want 0", done_cnt - d0); end
    wr_q.delete();
    pulse(1'b1, 1'b0, 1'b0);
    run_until_done(5000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: done=%b, want 1", done); end
    tick();
    check_save_data("restart");
  endtask

  task automatic test_load();
    int b0, w0;
    bit ok;
    stall = 0; spur_en = 1'b0;
    ld_seed = {$urandom, $urandom};
    wren_q.delete(); wr_q.delete();
    b0 = busy_cyc; w0 = wide_cnt;
    pulse(1'b0, 1'b1, 1'b0);
    run_until_done(5000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL load_timeout: done=%b, want 1", done); end
    tick();
    checks++;
    if (wren_q.size() != N) begin
      errors++; $display("FAIL load_count: got %0d wren, want %0d", wren_q.size(), N);
    end
    for (int i = 0; i < wren_q.size() && i < N; i++) begin
      checks++;
      if (wren_q[i].a !== 16'(i) || wren_q[i].d !== ld_word(16'(i))) begin
        errors++;
        $display("FAIL load_wren%0d: got %h/%h, want %h/%h", i,
                 wren_q[i].a, wren_q[i].d, 16'(i), ld_word(16'(i)));
      end
    end
    if (wren_q.size() > 19) begin
      checks++;
      if (wren_q[0].d !== 64'hE064_0000_0000_0000 || wren_q[19].d !== 64'h7FFF) begin
        errors++;
        $display("FAIL load_fixed: got %h/%h, want e064000000000000/7fff",
                 wren_q[0].d, wren_q[19].d);
      end
    end
    checks++;
    if (wide_cnt != w0) begin errors++; $display("FAIL load_wide: got %0d, want 0", wide_cnt - w0); end
    checks++;
    if (busy_cyc - b0 != N * 3) begin
      errors++; $display("FAIL load_busy: got %0d, want %0d", busy_cyc - b0, N * 3);
    end
    checks++;
    if (wr_q.size() != 0) begin errors++; $display("FAIL load_writes: got %0d, want 0", wr_q.size()); end
  endtask

  task automatic test_stall();
    int b0, v0;
    bit ok;
    stall = 5; spur_en = 1'b1;
    wr_q.delete();
    b0 = busy_cyc; v0 = viol_cnt;
    pulse(1'b1, 1'b0, 1'b0);
    run_until_done(10000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout: done=%b, want 1", done); end
    tick();
    spur_en = 1'b0;
    check_save_data("stall");
    checks++;
    if (viol_cnt != v0) begin errors++; $display("FAIL stall_hold: got %0d, want 0", viol_cnt - v0); end
    checks++;
    if (busy_cyc - b0 != N * (LAT + 5 + 2)) begin
      errors++;
      $display("FAIL stall_busy: got %0d, want %0d", busy_cyc - b0, N * (LAT + 7));
    end
    stall = 0;
  endtask

  task automatic test_priority();
    int r0;
    bit ok;
    stall = 0;
    wr_q.delete();
    r0 = rd_cnt;
    pulse(1'b1, 1'b1, 1'b0);
    repeat (30) tick();
    pulse(1'b0, 1'b1, 1'b0);
    run_until_done(5000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL prio_timeout: done=%b, want 1", done); end
    tick(); tick(); tick();
    checks++;
    if (rd_cnt != r0) begin errors++; $display("FAIL prio_reads: got %0d, want 0", rd_cnt - r0); end
    check_save_data("prio");
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL prio_queued: busy=%b, want 0", busy); end
  endtask

  task automatic test_defaults();
    int r0, rd0, rst_at, done_at;
    wr_q.delete();
    r0 = rst_cnt; rd0 = rd_cnt;
    rst_at = -1; done_at = -1;
    pulse(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      if (bus_rst && rst_at < 0) rst_at = k;
      if (done && done_at < 0) done_at = k;
      tick();
    end
    checks++;
    if (rst_cnt - r0 != 1) begin errors++; $display("FAIL def_rst: got %0d pulses, want 1", rst_cnt - r0); end
    checks++;
    if (rst_at != 1 || done_at != 2) begin
      errors++; $display("FAIL def_timing: rst@%0d done@%0d, want 1/2", rst_at, done_at);
    end
    checks++;
    if (wr_q.size() != 0 || rd_cnt != rd0) begin
      errors++; $display("FAIL def_mem: got %0d wr %0d rd, want 0", wr_q.size(), rd_cnt - rd0);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    wr2_q.delete();
    s2_save = 1'b1;
    tick();
    s2_save = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 2000) begin tick(); cyc++; end
    checks++;
    if (!done2) begin errors++; $display("FAIL wrap_timeout: done=%b, want 1", done2); end
    tick();
    checks++;
    if (wr2_q.size() != N2) begin
      errors++; $display("FAIL wrap_count: got %0d, want %0d", wr2_q.size(), N2);
    end
    for (int i = 0; i < wr2_q.size() && i < N2; i++) begin
      checks++;
      if (wr2_q[i].a !== 16'(BASE2 + 16'(i)) || wr2_q[i].d !== wrap_word(10'(i))) begin
        errors++;
        $display("FAIL wrap_wr%0d: got %h/%h, want %h/%h", i, wr2_q[i].a,
                 wr2_q[i].d, 16'(BASE2 + 16'(i)), wrap_word(10'(i)));
      end
    end
    if (wr2_q.size() > 16) begin
      checks++;
      if (wr2_q[15].a !== 16'hFFFF || wr2_q[16].a !== 16'h0000) begin
        errors++;
        $display("FAIL wrap_edge: got %h/%h, want ffff/0000", wr2_q[15].a, wr2_q[16].a);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b0, exp_busy;
    bit ok, is_load;
    for (int it = 0; it < 6; it++) begin
      is_load = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      ld_seed = {$urandom, $urandom};
      wr_q.delete(); wren_q.delete();
      b0 = busy_cyc;
      pulse(!is_load, is_load, 1'b0);
      run_until_done(8000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b%0d_timeout: done=%b, want 1", it, done); end
      tick();
      exp_busy = is_load ? N * (stall + 3) : N * (LAT + stall + 2);
      checks++;
      if (busy_cyc - b0 != exp_busy) begin
        errors++; $display("FAIL b2b%0d_busy: got %0d, want %0d", it, busy_cyc - b0, exp_busy);
      end
      if (is_load) begin
        checks++;
        if (wren_q.size() != N || wren_q[N-1].d !== ld_word(16'(N - 1))) begin
          errors++; $display("FAIL b2b%0d_load: got %0d wren, want %0d", it, wren_q.size(), N);
        end
      end else begin
        check_save_data("b2b");
      end
    end
    stall = 0;
  endtask

  initial begin
    test_reset();
    test_save();
    test_reset_mid_save();
    test_load();
    test_stall();
    test_priority();
    test_defaults();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/savestate_reg_sequencer.md
Name: savestate_reg_sequencer

Overview:
- Sits between the savestate register bus and the savestate memory port.
- On a save command it walks register indices 0..NUM_REGS-1 and reads each 64-bit register from the bus. It then writes each value to memory at BASE_ADDR+index.
- On a load command it reads each memory word back and writes it onto the bus at the same index.
- It also issues a one-cycle bus reset pulse, which makes every register take its default value.

Parameters:
- NUM_REGS, 64, number of indices walked; the index map (CPU 0-2 … SNDMAP5 52) fits within it.
- BUS_LAT, 2, cycles from driving SaveStateBus_Adr to SaveStateBus_Dout being valid (1..7).
- ADDR_W, 16, memory word-address width.
- BASE_ADDR, 0, memory word address of index 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ss_save  in  1  start-save pulse.
- ss_load  in  1  start-load pulse.
- ss_defaults  in  1  request a default-reset pulse on the bus.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- SaveStateBus_Adr  out  10  register index.
- SaveStateBus_Din  out  64  write data to registers.
- SaveStateBus_wren  out  1  register write strobe.
- SaveStateBus_rst  out  1  load-defaults strobe.
- SaveStateBus_Dout  in  64  OR-combined read data from the addressed register.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  64  write data.
- mem_rdata  in  64  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion.

Behaviour:
- Reset (reset_n low, asynchronous): every output is 0, index=0, wait counter=0, FSM=IDLE.
- The asynchronous reset aborts any sequence in flight immediately; no done pulse is produced.

States and transitions:
- IDLE
  - ss_defaults → DEF.
  - else ss_save → SV_ADR.
  - else ss_load → LD_REQ.
  - Priority when several are high together: defaults > save > load.
  - index is cleared to 0 on leaving IDLE; busy=1 in every state except IDLE.
  - Start pulses arriving while busy are ignored (not queued).
- DEF: SaveStateBus_rst=1 for exactly one cycle → FIN.
- SV_ADR
  - Drives SaveStateBus_Adr=index and counts BUS_LAT cycles.
  - On the last count it captures SaveStateBus_Dout into mem_wdata → SV_WR.
- SV_WR
  - mem_req=1, mem_we=1, mem_addr=BASE_ADDR+index.
  - Held until mem_ack is sampled high; mem_req drops the following cycle.
  - Then → NEXT_S.
- NEXT_S
  - If index==NUM_REGS-1 → FIN.
  - Else index+1 → SV_ADR.
- LD_REQ
  - mem_req=1, mem_we=0, mem_addr=BASE_ADDR+index.
  - On mem_ack it captures mem_rdata into SaveStateBus_Din → LD_WR.
- LD_WR
  - SaveStateBus_Adr=index, SaveStateBus_wren=1 for exactly one cycle.
  - Then → NEXT_L, which uses the same end test as NEXT_S and returns to LD_REQ.
- FIN: done=1 for one cycle, busy=0 → IDLE.

Bus and memory rules:
- SaveStateBus_Adr holds the current index in every non-IDLE state and is 0 in IDLE.
- mem_ack is accepted in the same cycle mem_req rises (zero wait).
- mem_ack seen while mem_req=0 is ignored.
- mem_addr = BASE_ADDR + index, truncated to ADDR_W bits; it wraps modulo 2^ADDR_W with no error.
- index is 10 bits. NUM_REGS=1 is legal and gives a single transfer.
- Indices with no register present read 0 on save and are written harmlessly on load; all NUM_REGS indices are always walked.

Latency:
- Save sequence: 1 + NUM_REGS·(BUS_LAT + ack_wait + 2) cycles, where ack_wait is the memory's response time per request.
- Load sequence: 1 + NUM_REGS·(ack_wait + 3) cycles.

Test Plan:
- Reset mid-save: assert reset_n=0 at index 5 → all outputs 0 and no done pulse; a subsequent ss_save starts again from index 0.
- Save, BUS_LAT=2, zero-wait memory:
  - Model Dout = 64'hA5A5_0000_0000_0000 | Adr.
  - Expect 64 writes, mem_addr 0..63 with wdata matching; index 0 carries 64'hA5A5000000000000.
  - done pulses once; busy is high throughout.
- Load, memory returning 64'hE064000000000000 at address 0 and 64'h0000000000007FFF at address 19:
  - wren pulses with Adr=0/Din=E064… and Adr=19/Din=7FFF.
  - Exactly 64 wren pulses, each one cycle wide.
- Memory stall of 5 cycles before every ack: mem_req is held steady and mem_addr is stable throughout each stall; no duplicate writes occur.
- ss_save and ss_load in the same cycle → save runs. ss_load pulsed while busy → ignored; mem_we stays 1 for the whole sequence.
- ss_defaults together with ss_save → single SaveStateBus_rst pulse, done pulses 2 cycles later, no memory traffic. With BASE_ADDR=16'hFFF0, a save wraps mem_addr from FFFF to 0000 at index 16.
